pf_iod_lvds_rx_bitslip_align: RTL
=================================

// Module: pf_iod_lvds_rx_bitslip_align
// PURPOSE
//  - Word-alignment controller for the LVDS RX lane, in the divided-clock domain.
//  - Compares each deserialized word with a known training pattern.
//  - Issues single-cycle BIT_SLIP pulses to the clock-divider/delay stage until
//    the word boundary matches, then declares lock.
//  - Sits downstream of the RX IOD deserializer; its BIT_SLIP output closes the
//    loop back to the clock divider.
// PARAMETERS
//  DATA_WIDTH     4        deserialized word width (bits per CLK cycle)
//  TRAIN_PATTERN  4'b1100  expected word once aligned (width DATA_WIDTH)
//  MATCH_COUNT    16       consecutive matches needed to declare lock (>=1)
//  SLIP_WAIT      8        settle cycles after each slip; data ignored (>=1)
//  MAX_SLIPS      8        slips allowed before FAIL (>=DATA_WIDTH)
//  LOSS_COUNT     4        consecutive mismatches in LOCKED that drop lock (>=1)
// PORTS
//  CLK         in   1           divided RX clock; all logic on rising edge
//  RST_N       in   1           asynchronous active-low reset
//  RX_DATA     in   DATA_WIDTH  deserialized word, valid every cycle
//  TRAIN_EN    in   1           level; 1 = training/monitoring active
//  BIT_SLIP    out  1           one-cycle slip request to the clock divider
//  RX_ALIGNED  out  1           1 while the FSM is in LOCKED
//  ALIGN_ERR   out  1           1 while the FSM is in FAIL
//  SLIP_CNT    out  $clog2(MAX_SLIPS+1)  slips issued in the current attempt
// BEHAVIOUR
//  - Reset values:
//    - All outputs and counters are 0; state is IDLE.
//    - Reset is asynchronous assert and synchronous-edge release.
//    - Reset mid-slip truncates BIT_SLIP immediately.
//  - All outputs are registered; no combinational path from input to output.
//  - States: IDLE, COMPARE, SLIP, WAIT, LOCKED, FAIL.
//  - IDLE:
//    - TRAIN_EN=1 -> COMPARE.
//    - Entering IDLE clears match_cnt, SLIP_CNT and the loss counter.
//  - COMPARE:
//    - RX_DATA==TRAIN_PATTERN: match_cnt+1.
//    - Reaching MATCH_COUNT -> LOCKED; RX_ALIGNED=1 on the next edge.
//    - Mismatch with SLIP_CNT<MAX_SLIPS -> SLIP; match_cnt cleared.
//    - Mismatch with SLIP_CNT==MAX_SLIPS -> FAIL.
//  - SLIP:
//    - Lasts exactly 1 cycle, with BIT_SLIP=1 and SLIP_CNT+1.
//    - Then -> WAIT.
//    - BIT_SLIP is never high for 2 consecutive cycles.
//  - WAIT:
//    - Counts SLIP_WAIT cycles, with RX_DATA ignored.
//    - Then -> COMPARE with match_cnt=0.
//  - LOCKED, TRAIN_EN=1 (monitoring):
//    - Each mismatch increments the loss counter; any match clears it.
//    - LOSS_COUNT consecutive mismatches -> COMPARE; RX_ALIGNED=0; SLIP_CNT=0.
//  - LOCKED, TRAIN_EN=0:
//    - Holds LOCKED (live traffic); the loss counter is frozen at 0.
//  - FAIL:
//    - ALIGN_ERR=1; holds until TRAIN_EN=0, then -> IDLE.
//  - TRAIN_EN=0 in COMPARE/SLIP/WAIT/FAIL -> IDLE on the next edge.
//    - A SLIP already in progress still completes its single cycle first.
//  - SLIP_CNT saturates at MAX_SLIPS; it never wraps.
//  - match_cnt saturates at MATCH_COUNT.
//  - Counter widths use $clog2(limit+1).
// STRUCTURE
//  - Shared package pf_iod_lvds_rx_pkg holds:
//    - the state enum typedef (align_state_t);
//    - default pattern/count constants, shared with the TX training generator.
//  - One natural sub-module: pf_iod_lvds_rx_sat_cnt.
//    - A parameterised saturating counter with clear/inc.
//    - Reused for match, settle, loss and slip counting.
// TESTING  (DATA_WIDTH=4, TRAIN_PATTERN=1100, MATCH_COUNT=16, SLIP_WAIT=8)
//  - Bench model: each BIT_SLIP rotates the stream by 1 bit, 2 cycles later.
//  1. Already aligned:
//     - Stimulus: TRAIN_EN=1, stream 1100 continuous.
//     - Required: 0 slips; RX_ALIGNED=1 exactly 17 cycles after TRAIN_EN rise.
//  2. Offset by 3 bits (0110 pattern phase):
//     - Required: 3 BIT_SLIP pulses, each 1 cycle wide, >=9 cycles apart.
//     - Then RX_ALIGNED=1 and SLIP_CNT=3.
//  3. Random data (never matches):
//     - Required: 8 slips, then ALIGN_ERR=1 and RX_ALIGNED=0.
//     - Deasserting TRAIN_EN clears ALIGN_ERR and SLIP_CNT next cycle.
//  4. Locked, then 3 bad words, then 1 good word:
//     - Required: stays LOCKED.
//     - 4 bad words -> RX_ALIGNED=0 on the next edge, then realignment.
//  5. Abort and reset:
//     - TRAIN_EN=0 during WAIT -> IDLE, with no further BIT_SLIP.
//     - RST_N=0 during SLIP -> BIT_SLIP=0 immediately; all outputs 0.

Source files
------------

// File: rtl/pf_iod_lvds_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pf_iod_lvds_rx_pkg
//  Description : Shared types and default training constants for the LVDS RX
//                lane. The TX training generator uses the same defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package pf_iod_lvds_rx_pkg;

    // Word-alignment controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPARE = 3'd1,
        ST_SLIP    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAIL    = 3'd5
    } align_state_t;

    // Default training parameters, common to TX generator and RX aligner
    localparam int         DEF_DATA_WIDTH    = 4;
    localparam logic [3:0] DEF_TRAIN_PATTERN = 4'b1100;
    localparam int         DEF_MATCH_COUNT   = 16;
    localparam int         DEF_SLIP_WAIT     = 8;
    localparam int         DEF_MAX_SLIPS     = 8;
    localparam int         DEF_LOSS_COUNT    = 4;

    // Bits needed for a counter that must be able to hold the value 'limit'
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pf_iod_lvds_rx_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pf_iod_lvds_rx_sat_cnt
//  Description : Saturating up-counter with synchronous clear. Clear wins over
//                increment; the count stops at LIMIT and never wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module pf_iod_lvds_rx_sat_cnt #(
    parameter int LIMIT = 8,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < C_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pf_iod_lvds_rx_bitslip_align.sv
`default_nettype none
// ============================================================================
//  Module      : pf_iod_lvds_rx_bitslip_align
//  Description : LVDS RX word-alignment controller (divided-clock domain).
//                Compares deserialized words against the training pattern,
//                pulses bit_slip_o to the clock divider until the boundary
//                matches, then reports lock and monitors for loss of lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module pf_iod_lvds_rx_bitslip_align
    import pf_iod_lvds_rx_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                    MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int                    SLIP_WAIT     = DEF_SLIP_WAIT,
    parameter int                    MAX_SLIPS     = DEF_MAX_SLIPS,
    parameter int                    LOSS_COUNT    = DEF_LOSS_COUNT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          rx_data_i,
    input  logic                           train_en_i,
    output logic                           bit_slip_o,
    output logic                           rx_aligned_o,
    output logic                           align_err_o,
    output logic [$clog2(MAX_SLIPS+1)-1:0] slip_cnt_o
);

    localparam int C_MATCH_W = cnt_width(MATCH_COUNT);
    localparam int C_WAIT_W  = cnt_width(SLIP_WAIT);
    localparam int C_LOSS_W  = cnt_width(LOSS_COUNT);
    localparam int C_SLIP_W  = cnt_width(MAX_SLIPS);

    // Terminal values: the transition fires on the cycle that completes the count
    localparam logic [C_MATCH_W-1:0] C_MATCH_LAST = C_MATCH_W'(MATCH_COUNT - 1);
    localparam logic [C_WAIT_W-1:0]  C_WAIT_LAST  = C_WAIT_W'(SLIP_WAIT - 1);
    localparam logic [C_LOSS_W-1:0]  C_LOSS_LAST  = C_LOSS_W'(LOSS_COUNT - 1);
    localparam logic [C_SLIP_W-1:0]  C_SLIP_MAX   = C_SLIP_W'(MAX_SLIPS);

    align_state_t state_q;
    align_state_t state_d;

    logic bit_slip_q;
    logic rx_aligned_q;
    logic align_err_q;

    logic [C_MATCH_W-1:0] match_cnt_q;
    logic [C_WAIT_W-1:0]  wait_cnt_q;
    logic [C_LOSS_W-1:0]  loss_cnt_q;
    logic [C_SLIP_W-1:0]  slip_cnt_q;

    logic w_match;
    logic w_match_clr;
    logic w_match_inc;
    logic w_wait_clr;
    logic w_wait_inc;
    logic w_loss_clr;
    logic w_loss_inc;
    logic w_slip_clr;
    logic w_slip_inc;

    assign w_match = (rx_data_i == TRAIN_PATTERN);

    // Next-state and counter control; every counter clears unless its state holds it
    always_comb begin
        state_d     = state_q;
        w_match_clr = 1'b1;
        w_match_inc = 1'b0;
        w_wait_clr  = 1'b1;
        w_wait_inc  = 1'b0;
        w_loss_clr  = 1'b1;
        w_loss_inc  = 1'b0;
        w_slip_clr  = 1'b0;
        w_slip_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (train_en_i) begin
                    state_d = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                if (!train_en_i) begin
                    state_d = ST_IDLE;
                end else if (w_match) begin
                    w_match_clr = 1'b0;
                    w_match_inc = 1'b1;
                    if (match_cnt_q == C_MATCH_LAST) begin
                        state_d = ST_LOCKED;
                    end
                end else if (slip_cnt_q < C_SLIP_MAX) begin
                    state_d    = ST_SLIP;
                    w_slip_inc = 1'b1;
                end else begin
                    state_d = ST_FAIL;
                end
            end

            // Slip pulse always lasts exactly one cycle, even when aborting
            ST_SLIP: begin
                state_d = train_en_i ? ST_WAIT : ST_IDLE;
            end

            // Divider/deserializer settle time: incoming data is ignored
            ST_WAIT: begin
                if (!train_en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    w_wait_clr = 1'b0;
                    w_wait_inc = 1'b1;
                    if (wait_cnt_q == C_WAIT_LAST) begin
                        state_d = ST_COMPARE;
                    end
                end
            end

            // Live traffic when train_en_i is low: hold lock, loss counter parked at 0
            ST_LOCKED: begin
                w_match_clr = 1'b0;
                if (train_en_i && !w_match) begin
                    if (loss_cnt_q == C_LOSS_LAST) begin
                        state_d     = ST_COMPARE;
                        w_match_clr = 1'b1;
                        w_slip_clr  = 1'b1;
                    end else begin
                        w_loss_clr = 1'b0;
                        w_loss_inc = 1'b1;
                    end
                end
            end

            ST_FAIL: begin
                if (!train_en_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new attempt starts from IDLE with a fresh slip budget
        if (state_d == ST_IDLE) begin
            w_slip_clr = 1'b1;
        end
    end

    // State and output registers; outputs decode the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_slip_q   <= 1'b0;
            rx_aligned_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_slip_q   <= (state_d == ST_SLIP);
            rx_aligned_q <= (state_d == ST_LOCKED);
            align_err_q  <= (state_d == ST_FAIL);
        end
    end

    pf_iod_lvds_rx_sat_cnt #(
        .LIMIT (MATCH_COUNT),
        .WIDTH (C_MATCH_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_match_clr),
        .inc_i (w_match_inc),
        .cnt_o (match_cnt_q)
    );

    pf_iod_lvds_rx_sat_cnt #(
        .LIMIT (SLIP_WAIT),
        .WIDTH (C_WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_wait_clr),
        .inc_i (w_wait_inc),
        .cnt_o (wait_cnt_q)
    );

    pf_iod_lvds_rx_sat_cnt #(
        .LIMIT (LOSS_COUNT),
        .WIDTH (C_LOSS_W)
    ) u_loss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_loss_clr),
        .inc_i (w_loss_inc),
        .cnt_o (loss_cnt_q)
    );

    pf_iod_lvds_rx_sat_cnt #(
        .LIMIT (MAX_SLIPS),
        .WIDTH (C_SLIP_W)
    ) u_slip_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_slip_clr),
        .inc_i (w_slip_inc),
        .cnt_o (slip_cnt_q)
    );

    assign bit_slip_o   = bit_slip_q;
    assign rx_aligned_o = rx_aligned_q;
    assign align_err_o  = align_err_q;
    assign slip_cnt_o   = slip_cnt_q;

endmodule
`default_nettype wire
